ofdm_tx_mapper: RTL



---
 rtl/ofdm_pkg.sv | 40 ++++
 rtl/ofdm_tx_mapper_bin_classify.sv | 31 +++
 rtl/ofdm_tx_mapper.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ofdm_pkg.sv
// ofdm_pkg: shared constants for the OFDM transmit mapper.
// Bin plan, pilot positions and BSRAM word layout.
package ofdm_pkg;

    localparam logic [10:0] PILOT0 = 11'd20;
    localparam logic [10:0] PILOT1 = 11'd21;
    localparam logic [10:0] PILOT2 = 11'd54;
    localparam logic [10:0] PILOT3 = 11'd87;
    localparam logic [10:0] PILOT4 = 11'd120;

    localparam logic [10:0] INDEX_BEGIN = 11'd20;
    localparam logic [10:0] INDEX_END   = 11'd120;

    localparam int          DATA_BITS   = 96;
    localparam logic [7:0]  HEADER_BYTE = 8'h55;

    // BSRAM word: real part in the upper half, imaginary in the lower.
    localparam int RE_MSB = 31;
    localparam int RE_LSB = 16;
    localparam int IM_MSB = 15;
    localparam int IM_LSB = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DONE
    } state_e;

    function automatic logic [31:0] pack_bin(
        input logic [15:0] re,
        input logic [15:0] im
    );
        logic [31:0] w;
        w = '0;
        w[RE_MSB:RE_LSB] = re;
        w[IM_MSB:IM_LSB] = im;
        return w;
    endfunction

endpackage

// File: rtl/ofdm_tx_mapper_bin_classify.sv
// ofdm_bin_classify: maps a bin index to pilot/data role.
// data_ordinal is the bin's position among the 96 data bins.
module ofdm_bin_classify
    import ofdm_pkg::*;
(
    input  logic [10:0] bin,
    output logic        is_pilot,
    output logic        is_data,
    output logic [6:0]  data_ordinal
);

    // Data bins sit in the three gaps between consecutive pilots.
    always_comb begin
        is_pilot     = (bin == PILOT0) || (bin == PILOT1) ||
                       (bin == PILOT2) || (bin == PILOT3) ||
                       (bin == PILOT4);
        is_data      = 1'b0;
        data_ordinal = 7'd0;
        if (bin > PILOT1 && bin < PILOT2) begin
            is_data      = 1'b1;
            data_ordinal = 7'(bin - (PILOT1 + 11'd1));
        end else if (bin > PILOT2 && bin < PILOT3) begin
            is_data      = 1'b1;
            data_ordinal = 7'(bin - (PILOT2 + 11'd1)) + 7'd32;
        end else if (bin > PILOT3 && bin < PILOT4) begin
            is_data      = 1'b1;
            data_ordinal = 7'(bin - (PILOT3 + 11'd1)) + 7'd64;
        end
    end

endmodule

// File: rtl/ofdm_tx_mapper.sv
// ofdm_tx_mapper: writes pilot + BPSK bins into the IFFT BSRAM.
// Optional OFDM_TX_MIRROR_EN makes the upper half Hermitian.
module ofdm_tx_mapper
    import ofdm_pkg::*;
#(
    parameter int          FFT_LEN         = 1024,
    parameter logic [15:0] PILOT_AMPLITUDE = 16'h4000,
    parameter logic [15:0] DATA_AMPLITUDE  = 16'h4000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [95:0] payload,
    output logic        busy,
    output logic        finish,
    output logic [31:0] din0,
    output logic [10:0] ad0,
    output logic        wre0,
    output logic        ce0,
    output logic        oce0
);

    localparam logic [10:0] LAST_BIN = 11'(FFT_LEN - 1);
    localparam logic [15:0] DATA_NEG = 16'(~DATA_AMPLITUDE + 16'd1);

    state_e      state_q, state_d;
    logic [10:0] k_q, k_d;
    logic [6:0]  j_q, j_d;
    logic [95:0] payload_q, payload_d;
    logic        busy_q, busy_d;
    logic        finish_q, finish_d;
    logic [31:0] din0_q, din0_d;
    logic [10:0] ad0_q, ad0_d;
    logic        wre0_q, wre0_d;
    logic        ce0_q, ce0_d;

    logic        dir_pilot;
    logic        dir_data;
    logic [6:0]  dir_ord;
    logic [15:0] re_dir;
    logic [15:0] re_k;
    logic        adv_j;
    logic        unused_ord;

    ofdm_bin_classify u_cls (
        .bin          (k_q),
        .is_pilot     (dir_pilot),
        .is_data      (dir_data),
        .data_ordinal (dir_ord)
    );

    // j counts data bins in order; the ordinal output is redundant here.
    assign unused_ord = ^dir_ord;

    // Value for bin k taken directly from the bin plan.
    always_comb begin
        re_dir = 16'h0000;
        if (dir_pilot) begin
            re_dir = PILOT_AMPLITUDE;
        end else if (dir_data) begin
            re_dir = payload_q[j_q ^ 7'd7] ? DATA_AMPLITUDE : DATA_NEG;
        end
    end

`ifdef OFDM_TX_MIRROR_EN
    localparam logic [10:0] HALF_BIN = 11'(FFT_LEN / 2);

    logic [10:0] mk;
    logic        in_mirror;
    logic        mir_pilot;
    logic        mir_data;
    logic [6:0]  mir_ord;
    logic [15:0] re_mir;

    assign mk        = 11'(FFT_LEN) - k_q;
    assign in_mirror = (k_q > HALF_BIN);

    ofdm_bin_classify u_mir (
        .bin          (mk),
        .is_pilot     (mir_pilot),
        .is_data      (mir_data),
        .data_ordinal (mir_ord)
    );

    // Upper half copies bin FFT_LEN-k; its bit comes from the ordinal.
    always_comb begin
        re_mir = 16'h0000;
        if (mir_pilot) begin
            re_mir = PILOT_AMPLITUDE;
        end else if (mir_data) begin
            re_mir = payload_q[mir_ord ^ 7'd7] ? DATA_AMPLITUDE : DATA_NEG;
        end
        re_k  = in_mirror ? re_mir : re_dir;
        adv_j = dir_data && !in_mirror;
    end
`else
    // Upper half stays zero; only the direct plan applies.
    always_comb begin
        re_k  = re_dir;
        adv_j = dir_data;
    end
`endif

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            j_q       <= '0;
            payload_q <= '0;
            busy_q    <= 1'b0;
            finish_q  <= 1'b0;
            din0_q    <= '0;
            ad0_q     <= '0;
            wre0_q    <= 1'b0;
            ce0_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            j_q       <= j_d;
            payload_q <= payload_d;
            busy_q    <= busy_d;
            finish_q  <= finish_d;
            din0_q    <= din0_d;
            ad0_q     <= ad0_d;
            wre0_q    <= wre0_d;
            ce0_q     <= ce0_d;
        end
    end

    // Next state: leave WRITE once the last bin is on the bus.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_WRITE;
            S_WRITE: if (ad0_q == LAST_BIN) state_d = S_DONE;
            S_DONE:  state_d = start ? S_WRITE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next outputs: bin 0 is issued on the accepting edge, k runs ahead.
    always_comb begin
        k_d       = k_q;
        j_d       = j_q;
        payload_d = payload_q;
        ad0_d     = ad0_q;
        din0_d    = din0_q;
        wre0_d    = 1'b0;
        ce0_d     = 1'b0;
        busy_d    = 1'b0;
        finish_d  = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    payload_d = payload;
                    j_d       = 7'd0;
                    k_d       = 11'd1;
                    ad0_d     = 11'd0;
                    din0_d    = 32'h0000_0000;
                    wre0_d    = 1'b1;
                    ce0_d     = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            S_WRITE: begin
                if (ad0_q == LAST_BIN) begin
                    finish_d = 1'b1;
                end else begin
                    ad0_d  = k_q;
                    din0_d = pack_bin(re_k, 16'h0000);
                    wre0_d = 1'b1;
                    ce0_d  = 1'b1;
                    busy_d = 1'b1;
                    k_d    = k_q + 11'd1;
                    if (adv_j) j_d = j_q + 7'd1;
                end
            end
            default: ;
        endcase
    end

    assign busy   = busy_q;
    assign finish = finish_q;
    assign din0   = din0_q;
    assign ad0    = ad0_q;
    assign wre0   = wre0_q;
    assign ce0    = ce0_q;
    assign oce0   = 1'b0;

endmodule
